// File: rtl/dmem_sync_pkg.sv
// Shared definitions for the synchronous data memory.
// Holds the access-size encodings, the controller state type and a helper
// that maps a size code to a byte count.
package dmem_sync_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  // Number of bytes touched by an access of the given size code.
  function automatic int unsigned size_bytes(input logic [1:0] sz);
    return 32'd1 << sz;
  endfunction

endpackage

// File: rtl/dmem_sync_lane_align.sv
// Combinational lane steering for dmem_sync.
// Ports:
//   size      - access size code (byte/half/word/dword)
//   off       - byte offset of the access inside the memory word
//   uns       - 1 = zero-extend loads, 0 = sign-extend
//   wdata     - store data, sub-word data in the low bits
//   rword     - full memory word being read
//   be        - byte-enable mask for the store
//   wshift    - store data moved into its byte lanes
//   rdata     - load data moved to the LSBs and extended
//   align_err - offset is illegal for the size (or size illegal for DATA_W)
module dmem_lane_align
  import dmem_sync_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LB     = 2
) (
  input  logic [1:0]          size,
  input  logic [LB-1:0]       off,
  input  logic                uns,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   rword,
  output logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   wshift,
  output logic [DATA_W-1:0]   rdata,
  output logic                align_err
);

  localparam int unsigned NB = DATA_W / 8;

  int unsigned          nbytes;
  int unsigned          nbits;
  int unsigned          offi;
  logic [DATA_W-1:0]    sh;

  always_comb begin
    offi   = 32'(off);
    nbytes = size_bytes(size);
    // A dword on a 32-bit memory is rejected anyway; clamp so the lane
    // arithmetic below stays inside the word.
    if (nbytes > NB) nbytes = NB;
    nbits  = nbytes * 8;

    be = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if ((i >= offi) && (i < offi + nbytes)) be[i] = 1'b1;
    end

    wshift = wdata << (offi * 8);
    sh     = rword >> (offi * 8);

    rdata = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (i < nbits) rdata[i] = sh[i];
      else           rdata[i] = uns ? 1'b0 : sh[nbits-1];
    end

    align_err = 1'b0;
    case (size_e'(size))
      SZ_B: align_err = 1'b0;
      SZ_H: align_err = off[0];
      SZ_W: align_err = (off[1:0] != 2'b00);
      SZ_D: align_err = (DATA_W == 32) || (off != '0);
      default: align_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_sync.sv
// Synchronous data memory for the MIPS datapath.
// Byte-addressed byte/half/word/dword loads and stores with a registered
// read port, an optional zero-fill sweep after reset, and detection and
// saturating counting of misaligned or out-of-range requests.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   Ewr, Erd   - write / read request
//   Size, Uns  - access size code, zero-extend select for loads
//   Addr       - byte address
//   WData      - store data (sub-word data in the low bits)
//   MOut       - registered load data, MValid pulses when it is new
//   Ready      - requests are accepted
//   Misalign   - pulses the cycle after a rejected request
//   ErrCnt     - saturating count of rejected requests
module dmem_sync
  import dmem_sync_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DEPTH          = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter int unsigned ERR_W          = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Ewr,
  input  logic              Erd,
  input  logic [1:0]        Size,
  input  logic              Uns,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WData,
  output logic [DATA_W-1:0] MOut,
  output logic              MValid,
  output logic              Ready,
  output logic              Misalign,
  output logic [ERR_W-1:0]  ErrCnt
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned LB = $clog2(NB);
  localparam int unsigned IW = ADDR_W - LB;
  localparam int unsigned XW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] DEPTH_V = IW'(DEPTH);
  localparam logic [XW-1:0] LAST    = XW'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_e          state, state_nx;
  logic [XW-1:0]   idx, idx_nx;

  logic [IW-1:0]     word_idx;
  logic [LB-1:0]     off;
  logic [XW-1:0]     widx;
  logic [DATA_W-1:0] rword;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wshift;
  logic [DATA_W-1:0] rdata;
  logic              align_err;
  logic              req, bad, rej, wr_ok, rd_ok, sweep_we;

  assign word_idx = Addr[ADDR_W-1:LB];
  assign off      = Addr[LB-1:0];
  assign widx     = word_idx[XW-1:0];
  assign rword    = mem[widx];

  dmem_lane_align #(
    .DATA_W (DATA_W),
    .LB     (LB)
  ) u_align (
    .size      (Size),
    .off       (off),
    .uns       (Uns),
    .wdata     (WData),
    .rword     (rword),
    .be        (be),
    .wshift    (wshift),
    .rdata     (rdata),
    .align_err (align_err)
  );

  assign Ready    = (state == ST_IDLE);
  assign req      = Ready && (Ewr || Erd);
  assign bad      = (word_idx >= DEPTH_V) || align_err || (Ewr && Erd);
  assign rej      = req && bad;
  assign wr_ok    = req && !bad && Ewr;
  assign rd_ok    = req && !bad && Erd;
  assign sweep_we = (state == ST_INIT) && (CLEAR_ON_RESET != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      ST_INIT: begin
        if (CLEAR_ON_RESET != 0) begin
          idx_nx = idx + 1'b1;
          if (idx == LAST) begin
            state_nx = ST_IDLE;
            idx_nx   = '0;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_IDLE: state_nx = ST_IDLE;
      default: state_nx = ST_INIT;
    endcase
  end

  // The array has no reset; only the sweep or an accepted store writes it.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[idx] <= '0;
    end else if (wr_ok) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wshift[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MOut     <= '0;
      MValid   <= 1'b0;
      Misalign <= 1'b0;
      ErrCnt   <= '0;
    end else begin
      MValid   <= rd_ok;
      Misalign <= rej;
      if (rd_ok) MOut <= rdata;
      if (rej && (ErrCnt != '1)) ErrCnt <= ErrCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_sync.sv
module tb_dmem_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Ewr, Erd, Uns;
  logic [1:0]  Size;
  logic [31:0] Addr, WData;
  logic [31:0] MOut;
  logic        MValid, Ready, Misalign;
  logic [7:0]  ErrCnt;

  dmem_sync #(
    .DATA_W         (32),
    .DEPTH          (32),
    .ADDR_W         (32),
    .CLEAR_ON_RESET (1),
    .ERR_W          (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Ewr      (Ewr),
    .Erd      (Erd),
    .Size     (Size),
    .Uns      (Uns),
    .Addr     (Addr),
    .WData    (WData),
    .MOut     (MOut),
    .MValid   (MValid),
    .Ready    (Ready),
    .Misalign (Misalign),
    .ErrCnt   (ErrCnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: byte-addressed memory, last load value, error count.
  logic [7:0]  mb [0:127];
  logic [31:0] exp_mout;
  int          exp_err;

  function automatic logic m_reject(input logic ew, input logic er,
                                    input logic [1:0] sz, input logic [31:0] a);
    return (a >= 32'd128) || (sz == 2'd1 && a % 2 != 0) ||
           (sz == 2'd2 && a % 4 != 0) || (sz == 2'd3) || (ew && er);
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic un,
                                         input logic [31:0] a);
    int unsigned n;
    logic [31:0] v;
    n = 1 << sz;
    v = '0;
    for (int unsigned i = 0; i < n; i++) v = v | (32'(mb[a + i]) << (8 * i));
    if (n < 4 && !un && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 128; i++) mb[i] = 8'h00;
    exp_mout = '0;
    exp_err  = 0;
  endtask

  // Drive one request starting at a falling edge, check the cycle after.
  task automatic drive_req(input logic ew, input logic er, input logic [1:0] sz,
                           input logic un, input logic [31:0] a, input logic [31:0] wd);
    logic acc, rej, rd;
    Ewr = ew; Erd = er; Size = sz; Uns = un; Addr = a; WData = wd;
    acc = ew | er;
    rej = acc && m_reject(ew, er, sz, a);
    rd  = acc && !rej && er;
    @(posedge clk); #1;
    if (rd) exp_mout = m_load(sz, un, a);
    if (acc && !rej && ew)
      for (int unsigned i = 0; i < (1 << sz); i++) mb[a + i] = wd[8*i +: 8];
    if (rej && exp_err < 255) exp_err++;
    checks++;
    if (MValid !== rd) begin
      errors++; $display("FAIL mvalid addr=%h got %b exp %b", a, MValid, rd);
    end
    checks++;
    if (Misalign !== rej) begin
      errors++; $display("FAIL misalign addr=%h got %b exp %b", a, Misalign, rej);
    end
    checks++;
    if (MOut !== exp_mout) begin
      errors++; $display("FAIL mout addr=%h size=%0d got %h exp %h", a, sz, MOut, exp_mout);
    end
    checks++;
    if (ErrCnt !== 8'(exp_err)) begin
      errors++; $display("FAIL errcnt got %0d exp %0d", ErrCnt, exp_err);
    end
    checks++;
    if (Ready !== 1'b1) begin
      errors++; $display("FAIL ready_idle got %b exp 1", Ready);
    end
    @(negedge clk);
    Ewr = 1'b0; Erd = 1'b0;
  endtask

  // Counts edges from reset release until Ready; entered at a falling edge.
  task automatic wait_ready(input string tag);
    int cnt;
    cnt = 0;
    while (Ready !== 1'b1 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    checks++;
    if (cnt !== 32) begin
      errors++; $display("FAIL %s sweep_len got %0d exp 32", tag, cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; Ewr = 0; Erd = 0; Size = 2'd2; Uns = 0; Addr = '0; WData = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({MOut, MValid, Ready, Misalign, ErrCnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got mout=%h v=%b r=%b m=%b e=%0d exp all 0",
               MOut, MValid, Ready, Misalign, ErrCnt);
    end
    rst_n = 1'b1;
    wait_ready("init");
    model_clear();
    drive_req(0, 1, 2'd2, 0, 32'h7C, '0);
    checks++;
    if (MOut !== 32'h0) begin
      errors++; $display("FAIL read_7c got %h exp 00000000", MOut);
    end
  endtask

  task automatic test_subword();
    drive_req(1, 0, 2'd2, 0, 32'h10, 32'h8899AABB);
    drive_req(1, 0, 2'd0, 0, 32'h11, 32'h123456FF);
    drive_req(0, 1, 2'd2, 0, 32'h10, '0);
    checks++;
    if (MOut !== 32'h8899FFBB) begin
      errors++; $display("FAIL sb_merge got %h exp 8899ffbb", MOut);
    end
    drive_req(0, 1, 2'd0, 0, 32'h13, '0);
    checks++;
    if (MOut !== 32'hFFFFFF88) begin
      errors++; $display("FAIL lb got %h exp ffffff88", MOut);
    end
    drive_req(0, 1, 2'd0, 1, 32'h13, '0);
    checks++;
    if (MOut !== 32'h00000088) begin
      errors++; $display("FAIL lbu got %h exp 00000088", MOut);
    end
    drive_req(0, 1, 2'd1, 1, 32'h12, '0);
    checks++;
    if (MOut !== 32'h00008899) begin
      errors++; $display("FAIL lhu got %h exp 00008899", MOut);
    end
    // Store followed immediately by a load of the same word.
    drive_req(1, 0, 2'd1, 0, 32'h12, 32'h0000_8001);
    drive_req(0, 1, 2'd1, 0, 32'h12, '0);
    checks++;
    if (MOut !== 32'hFFFF8001) begin
      errors++; $display("FAIL raw_lh got %h exp ffff8001", MOut);
    end
  endtask

  task automatic test_misalign();
    drive_req(1, 0, 2'd1, 0, 32'h05, 32'hDEADBEEF);
    drive_req(0, 1, 2'd2, 0, 32'h06, '0);
    drive_req(0, 1, 2'd2, 0, 32'h80, '0);
    checks++;
    if (ErrCnt !== 8'd3) begin
      errors++; $display("FAIL misalign_count got %0d exp 3", ErrCnt);
    end
    drive_req(0, 1, 2'd2, 0, 32'h04, '0);
    checks++;
    if (MOut !== 32'h0) begin
      errors++; $display("FAIL misalign_nowrite got %h exp 00000000", MOut);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      int unsigned op;
      logic ew, er;
      op = $urandom_range(0, 9);
      ew = (op < 4) || (op == 9);
      er = (op >= 4 && op < 8) || (op == 9);
      drive_req(ew, er, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 159)), $urandom);
    end
  endtask

  task automatic test_saturate();
    drive_req(1, 1, 2'd2, 0, 32'h20, 32'h1);
    for (int n = 0; n < 300; n++)
      drive_req(1, 1, 2'($urandom_range(0, 2)), 0, 32'($urandom_range(0, 127)), $urandom);
    checks++;
    if (ErrCnt !== 8'd255) begin
      errors++; $display("FAIL errcnt_sat got %0d exp 255", ErrCnt);
    end
  endtask

  task automatic test_sweep_reset();
    mb[32'h10] = 8'h5A;
    drive_req(1, 0, 2'd0, 0, 32'h10, 32'h5A);
    drive_req(0, 1, 2'd0, 1, 32'h10, '0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({MOut, MValid, Ready, Misalign, ErrCnt} !== '0) begin
      errors++;
      $display("FAIL async_reset got mout=%h v=%b r=%b m=%b e=%0d exp all 0",
               MOut, MValid, Ready, Misalign, ErrCnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      Ewr = 1'($urandom_range(0, 1)); Erd = ~Ewr | 1'($urandom_range(0, 1));
      Size = 2'($urandom_range(0, 3)); Addr = 32'($urandom_range(0, 255));
      WData = $urandom;
      @(posedge clk); #1;
      checks++;
      if ({Ready, Misalign, MValid, ErrCnt} !== '0) begin
        errors++;
        $display("FAIL sweep_ignore cyc=%0d got r=%b m=%b v=%b e=%0d exp all 0",
                 c, Ready, Misalign, MValid, ErrCnt);
      end
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    Ewr = 1'b0; Erd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("restart");
    model_clear();
    drive_req(0, 1, 2'd2, 0, 32'h10, '0);
    checks++;
    if (MOut !== 32'h0) begin
      errors++; $display("FAIL sweep_cleared got %h exp 00000000", MOut);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_subword();
    test_misalign();
    test_random();
    test_saturate();
    test_sweep_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
